mac_operand_sequencer: RTL and testbench

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

---
 rtl/nn_pkg.sv | 9 +
 rtl/mac_operand_sequencer_weight_ram.sv | 17 +
 rtl/mac_operand_sequencer.sv | 91 +++++++++
 tb/tb_mac_operand_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, sequencer FSM states and the ReLU helper
package nn_pkg;
  localparam int ACT_W = 8;
  localparam int ACC_W = 16;
  typedef enum logic [2:0] {LOAD, ISSUE, DRAIN, OUT, CLEAR} state_t;
  function automatic logic [ACC_W-1:0] relu16(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? '0 : v;
  endfunction
endpackage

// File: rtl/mac_operand_sequencer_weight_ram.sv
// weight_ram: single-write, combinational-read weight store (not reset)
module weight_ram #(
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: feeds x/weight operand pairs to an external MAC, one neuron at a time, and streams ReLU results
module mac_operand_sequencer
  import nn_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 2,
  localparam int AW = $clog2(M*N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [ACT_W-1:0] s_data,
  input  logic             w_wr_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [ACT_W-1:0] w_data,
  output logic [ACT_W-1:0] mac_a,
  output logic [ACT_W-1:0] mac_b,
  output logic             mac_valid,
  output logic             mac_clear,
  input  logic [ACC_W-1:0] mac_f,
  input  logic             mac_valid_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_data
);
  localparam int EW = $clog2(N);
  localparam int NW = M > 1 ? $clog2(M) : 1;
  localparam int CW = $clog2(N+1);
  localparam logic [EW-1:0] E_LAST = EW'(N-1);
  localparam logic [NW-1:0] N_LAST = NW'(M-1);
  localparam logic [CW-1:0] C_FULL = CW'(N);
  state_t state, state_nx;
  logic [EW-1:0] k, elem;
  logic [NW-1:0] neuron;
  logic [CW-1:0] count, count_nx;
  logic [ACT_W-1:0] x_buf [N];
  logic [ACT_W-1:0] w_rd;
  logic [AW-1:0] rd_addr;
  logic beat, pulse, done;
  assign beat = state == LOAD && s_valid;
  // pulses are counted from the first issue cycle so an early MAC response is not lost
  assign pulse = mac_valid_out && (state == ISSUE || state == DRAIN);
  assign count_nx = count + CW'(pulse);
  assign done = state == DRAIN && count_nx == C_FULL;
  assign rd_addr = AW'(neuron) * AW'(N) + AW'(elem);
  weight_ram #(.DEPTH(M*N), .AW(AW), .DW(ACT_W)) u_wram (
    .clk    (clk),
    .wr_en  (w_wr_en && state == LOAD),
    .wr_addr(w_addr),
    .wr_data(w_data),
    .rd_addr(rd_addr),
    .rd_data(w_rd)
  );
  always_ff @(posedge clk) state <= reset ? LOAD : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (beat && k == E_LAST) state_nx = ISSUE;
      ISSUE:   if (elem == E_LAST) state_nx = DRAIN;
      DRAIN:   if (done) state_nx = OUT;
      OUT:     if (m_ready) state_nx = CLEAR;
      CLEAR:   state_nx = neuron == N_LAST ? LOAD : ISSUE;
      default: state_nx = LOAD;
    endcase
  end
  always_comb begin
    s_ready = state == LOAD && !reset;
    mac_valid = state == ISSUE && !reset;
    mac_a = mac_valid ? x_buf[elem] : '0;
    mac_b = mac_valid ? w_rd : '0;
    mac_clear = reset || state == CLEAR;
    m_valid = state == OUT && !reset;
  end
  always_ff @(posedge clk) if (beat) x_buf[k] <= s_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      k <= '0;
      elem <= '0;
      neuron <= '0;
      count <= '0;
      m_data <= '0;
    end else begin
      if (beat) k <= k == E_LAST ? '0 : k + EW'(1);
      if (state == ISSUE) elem <= elem == E_LAST ? '0 : elem + EW'(1);
      if (state == CLEAR) neuron <= neuron == N_LAST ? '0 : neuron + NW'(1);
      count <= state == CLEAR ? '0 : count_nx;
      if (done) m_data <= relu16(mac_f);
    end
  end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: table-driven bench with a 3-cycle MAC model and operand scoreboard
module tb_mac_operand_sequencer;
  localparam int N = 4;
  localparam int M = 2;
  logic clk = 0;
  logic reset, s_valid, s_ready, w_wr_en, mac_valid, mac_clear, mac_valid_out, m_valid, m_ready;
  logic [7:0] s_data, w_data, mac_a, mac_b;
  logic [2:0] w_addr;
  logic [15:0] mac_f, m_data;
  mac_operand_sequencer #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid), .mac_clear(mac_clear),
    .mac_f(mac_f), .mac_valid_out(mac_valid_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0][7:0] x;
    logic [7:0][7:0] w;
    int stall;
    bit tog;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;
  vec_t vt [6];
  int tests = 0, fails = 0;
  logic [3:0][7:0] x_m;
  logic [7:0][7:0] w_m;
  int cyc = 0, clr_cnt = 0, pulse_cnt = 0, pulses = 0, pulse_bad = 0;
  int iss = 0, op_cnt = 0, op_err = 0;
  logic v1 = 0, v2 = 0, v3 = 0;
  logic signed [15:0] p1 = 0, p2 = 0, acc = 0;
  assign mac_f = acc;
  assign mac_valid_out = v3;
  // reference MAC: product issued at t accumulates and pulses at t+3
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_clear) begin
      v1 <= 0; v2 <= 0; v3 <= 0; acc <= 0; pulses <= 0;
      if (!reset) begin
        clr_cnt <= clr_cnt + 1;
        if (pulses != N) pulse_bad <= pulse_bad + 1;
      end
    end else begin
      v1 <= mac_valid;
      p1 <= $signed(mac_a) * $signed(mac_b);
      v2 <= v1;
      p2 <= p1;
      v3 <= v2;
      if (v2) acc <= acc + p2;
      if (v3) begin
        pulses <= pulses + 1;
        pulse_cnt <= pulse_cnt + 1;
      end
    end
  end
  always @(negedge clk) begin
    if (reset) iss = 0;
    else if (mac_valid) begin
      op_cnt++;
      if (mac_a !== x_m[iss % N] || mac_b !== w_m[iss]) op_err++;
      iss = (iss + 1) % (N * M);
    end else if (mac_a !== 8'd0 || mac_b !== 8'd0) op_err++;
  end
  function automatic logic [3:0][7:0] mk4(input int a, input int b, input int c, input int d);
    logic [3:0][7:0] r;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic load_w(input logic [7:0][7:0] w);
    for (int i = 0; i < 8; i++) begin
      w_wr_en = 1; w_addr = 3'(i); w_data = w[i]; w_m[i] = w[i];
      @(posedge clk); #1;
    end
    w_wr_en = 0;
  endtask
  task automatic stream(input logic [3:0][7:0] x, input bit tog);
    x_m = x;
    for (int i = 0; i < 4; i++) begin
      if (tog && i > 0) begin
        s_valid = 0; s_data = 8'h55;
        @(negedge clk) chk("gap no issue", 32'(mac_valid), 0);
        @(posedge clk); #1;
      end
      s_valid = 1; s_data = x[i];
      if (i == 3) @(negedge clk) chk("ready before last beat", {s_ready, mac_valid}, 2'b10);
      @(posedge clk); #1;
    end
    s_valid = 0;
    @(negedge clk) chk("issue starts", {mac_valid, mac_a}, {1'b1, x[0]});
  endtask
  task automatic get_result(input logic [15:0] exp, input int stall, input string nm, output int t);
    bit found = 0;
    t = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_valid) begin found = 1; break; end
    end
    chk({nm, " valid"}, 32'(found), 1);
    if (found) begin
      chk(nm, 32'(m_data), 32'(exp));
      t = cyc;
      for (int j = 0; j < stall; j++)
        @(negedge clk) chk("stall hold", {m_valid, m_data, mac_valid}, {1'b1, exp, 1'b0});
    end
    m_ready = 1;
  endtask
  task automatic wait_ready();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    chk("s_ready back", 32'(s_ready), 1);
  endtask
  task automatic run_vec(input int i);
    int c0, o0, p0, t0, t1;
    c0 = clr_cnt; o0 = op_cnt; p0 = pulse_cnt;
    load_w(vt[i].w);
    m_ready = vt[i].stall == 0;
    stream(vt[i].x, vt[i].tog);
    get_result(vt[i].e0, vt[i].stall, "neuron0", t0);
    get_result(vt[i].e1, 0, "neuron1", t1);
    if (vt[i].stall == 0) chk("neuron spacing", t1 - t0, 9);
    wait_ready();
    chk("clear pulses", clr_cnt - c0, 2);
    chk("issued ops", op_cnt - o0, 8);
    chk("mac pulses", pulse_cnt - p0, 8);
    chk("operand errors", op_err, 0);
    chk("per-neuron pulse errors", pulse_bad, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end
  initial begin
    int t0, t1;
    bit bad;
    vt[0] = '{mk4(1,2,3,4), {mk4(-1,-1,-1,-1), mk4(1,1,1,1)}, 0, 0, 16'd10, 16'd0};
    vt[1] = '{mk4(1,2,3,4), {mk4(-1,-1,-1,-1), mk4(1,1,1,1)}, 5, 0, 16'd10, 16'd0};
    vt[2] = '{mk4(1,2,3,4), {mk4(-1,-1,-1,-1), mk4(1,1,1,1)}, 0, 1, 16'd10, 16'd0};
    vt[3] = '{mk4(-1,-2,-3,-4), {mk4(-1,-1,-1,-1), mk4(1,1,1,1)}, 0, 0, 16'd0, 16'd10};
    vt[4] = '{mk4(10,20,30,40), {mk4(-2,0,1,1), mk4(1,2,3,4)}, 0, 0, 16'd300, 16'd50};
    vt[5] = '{mk4(100,-50,25,3), {mk4(1,-1,1,-1), mk4(2,2,2,2)}, 0, 0, 16'd156, 16'd172};
    reset = 1; s_valid = 0; s_data = 0; w_wr_en = 0; w_addr = 0; w_data = 0; m_ready = 0;
    x_m = '0; w_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mac_clear", 32'(mac_clear), 1);
    chk("reset m_valid/mac_valid", {m_valid, mac_valid}, 2'b00);
    chk("reset m_data", 32'(m_data), 0);
    chk("reset operands", {mac_a, mac_b}, 16'd0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk) chk("s_ready after reset", {s_ready, mac_clear}, 2'b10);
    for (int i = 0; i < 6; i++) run_vec(i);
    load_w(vt[0].w);
    m_ready = 1;
    stream(mk4(1,2,3,4), 0);
    w_wr_en = 1; w_addr = 3'd0; w_data = 8'd5;
    @(posedge clk); #1 w_wr_en = 0;
    get_result(16'd10, 0, "write ignored n0", t0);
    get_result(16'd0, 0, "write ignored n1", t1);
    wait_ready();
    stream(mk4(1,2,3,4), 0);
    @(posedge clk); #1 reset = 1;
    @(negedge clk) chk("mid reset outputs", {mac_clear, mac_valid, m_valid}, 3'b100);
    @(posedge clk); #1 reset = 0;
    @(negedge clk) chk("after mid reset", {s_ready, m_valid, mac_valid}, 3'b100);
    bad = 0;
    repeat (10) @(negedge clk) if (m_valid) bad = 1;
    chk("no partial result", 32'(bad), 0);
    stream(mk4(2,2,2,2), 0);
    get_result(16'd8, 0, "reload n0", t0);
    get_result(16'd0, 0, "reload n1", t1);
    chk("reload spacing", t1 - t0, 9);
    wait_ready();
    chk("final operand errors", op_err, 0);
    chk("final pulse errors", pulse_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
